// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic instruction requests into 32-bit MIPS words and writes
// them sequentially into instruction memory.
// Latency: request accepted in cycle N -> im_we/im_addr/im_wdata registered in cycle N+1.
// Backpressure: in_ready is high only while a session runs with room left (count < DEPTH).
// Optional feature macro: NOP_FILL_EN (adds a one-cycle delay-slot NOP fill after
// beq/j/jal/jr); with it undefined, branches encode like any other op.
module instr_encoder #(
  parameter int ADDR_W = 10,   // word-address width of im_addr
  parameter int DEPTH  = 1024  // words per session, 1 <= DEPTH <= 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [25:0]       in_imm,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [ADDR_W:0]   count
);

  // Symbolic op identifiers presented on in_op
  localparam logic [3:0] OP_ADDU = 4'd0;
  localparam logic [3:0] OP_SUBU = 4'd1;
  localparam logic [3:0] OP_ORI  = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_SW   = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;
  localparam logic [3:0] OP_LUI  = 4'd6;
  localparam logic [3:0] OP_JAL  = 4'd7;
  localparam logic [3:0] OP_J    = 4'd8;
  localparam logic [3:0] OP_JR   = 4'd9;
  localparam logic [3:0] OP_NOP  = 4'd10;

  // MIPS primary opcodes and R-type function codes
  localparam logic [5:0] MOP_RTYPE = 6'b000000;
  localparam logic [5:0] MOP_ORI   = 6'b001101;
  localparam logic [5:0] MOP_LW    = 6'b100011;
  localparam logic [5:0] MOP_SW    = 6'b101011;
  localparam logic [5:0] MOP_BEQ   = 6'b000100;
  localparam logic [5:0] MOP_LUI   = 6'b001111;
  localparam logic [5:0] MOP_JAL   = 6'b000011;
  localparam logic [5:0] MOP_J     = 6'b000010;
  localparam logic [5:0] FN_ADDU   = 6'b100001;
  localparam logic [5:0] FN_SUBU   = 6'b100011;
  localparam logic [5:0] FN_JR     = 6'b001000;

  // Session limit at the width of the word counter
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_FILL = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_im_we;
  logic [ADDR_W-1:0]   r_im_addr;
  logic [31:0]         r_im_wdata;
  logic                r_busy;
  logic                r_done;
  logic                r_illegal;
  logic [ADDR_W:0]     r_count;

  logic [31:0]         w_word;
  logic                w_legal;
  logic [15:0]         w_imm16;
  logic [ADDR_W:0]     w_count_inc;
  logic                w_full_next;
  logic                w_accept;
`ifdef NOP_FILL_EN
  logic                w_branch;
`endif

  assign w_imm16     = in_imm[15:0];
  assign w_count_inc = r_count + 1'b1;
  // The write about to happen (request or fill) uses up the last free slot
  assign w_full_next = (w_count_inc == LP_DEPTH);
  assign in_ready    = (r_state == S_RUN) && (r_count < LP_DEPTH);
  assign w_accept    = in_valid & in_ready;

  // Encode the presented request into a MIPS word; ops 11-15 flag as illegal
  always_comb begin
    w_word  = 32'h0000_0000;
    w_legal = 1'b1;
    case (in_op)
      OP_ADDU: w_word = {MOP_RTYPE, in_rs, in_rt, in_rd, 5'b00000, FN_ADDU};
      OP_SUBU: w_word = {MOP_RTYPE, in_rs, in_rt, in_rd, 5'b00000, FN_SUBU};
      OP_ORI:  w_word = {MOP_ORI,   in_rs, in_rt, w_imm16};
      OP_LW:   w_word = {MOP_LW,    in_rs, in_rt, w_imm16};
      OP_SW:   w_word = {MOP_SW,    in_rs, in_rt, w_imm16};
      OP_BEQ:  w_word = {MOP_BEQ,   in_rs, in_rt, w_imm16};
      OP_LUI:  w_word = {MOP_LUI,   5'b00000, in_rt, w_imm16};
      OP_JAL:  w_word = {MOP_JAL,   in_imm};
      OP_J:    w_word = {MOP_J,     in_imm};
      OP_JR:   w_word = {MOP_RTYPE, in_rs, 15'b0, FN_JR};
      OP_NOP:  w_word = 32'h0000_0000;
      default: w_legal = 1'b0;
    endcase
  end

`ifdef NOP_FILL_EN
  // Control transfers that need a delay-slot NOP written after them
  always_comb begin
    w_branch = 1'b0;
    case (in_op)
      OP_BEQ, OP_JAL, OP_J, OP_JR: w_branch = 1'b1;
      default:                     w_branch = 1'b0;
    endcase
  end
`endif

  // Session FSM with registered IM write port and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_im_we    <= 1'b0;
      r_im_addr  <= '0;
      r_im_wdata <= 32'h0000_0000;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_illegal  <= 1'b0;
      r_count    <= '0;
    end else begin
      // The write strobe is a single-cycle pulse per word
      r_im_we <= 1'b0;
      if (start) begin
        // start has priority over finish and over a request in the same cycle
        r_state   <= S_RUN;
        r_count   <= '0;
        r_illegal <= 1'b0;
        r_done    <= 1'b0;
        r_busy    <= 1'b1;
      end else begin
        case (r_state)
          S_RUN: begin
            if (w_accept) begin
              if (w_legal) begin
                r_im_we    <= 1'b1;
                r_im_addr  <= r_count[ADDR_W-1:0];
                r_im_wdata <= w_word;
                r_count    <= w_count_inc;
              end else begin
                r_illegal  <= 1'b1;
              end
              // The accepted word is still written when finish coincides with it
              if (finish || (w_legal && w_full_next)) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
`ifdef NOP_FILL_EN
              else if (w_legal && w_branch) begin
                r_state <= S_FILL;
              end
`endif
            end else if (finish) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
`ifdef NOP_FILL_EN
          S_FILL: begin
            // Delay-slot NOP; a finish seen here takes effect once it is written
            r_im_we    <= 1'b1;
            r_im_addr  <= r_count[ADDR_W-1:0];
            r_im_wdata <= 32'h0000_0000;
            r_count    <= w_count_inc;
            if (finish || w_full_next) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
`endif
          default: begin
            // IDLE and DONE wait for start
          end
        endcase
      end
    end
  end

  assign im_we    = r_im_we;
  assign im_addr  = r_im_addr;
  assign im_wdata = r_im_wdata;
  assign busy     = r_busy;
  assign done     = r_done;
  assign illegal  = r_illegal;
  assign count    = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder (default build, NOP fill disabled) with a small session model.
// DUT built with ADDR_W=4, DEPTH=12 so the session limit is reachable quickly.
// Directed cases first, then randomized start/finish/request traffic.
module tb_instr_encoder;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 12;

  logic              clk;
  logic              reset;
  logic              start;
  logic              finish;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [25:0]       in_imm;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              busy;
  logic              done;
  logic              illegal;
  logic [ADDR_W:0]   count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference session state
  bit m_sess;
  int m_cnt;
  bit m_ill;
  bit m_done;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .busy(busy), .done(done), .illegal(illegal), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // MIPS word from field values, built with plain shifts and sums
  function automatic bit [31:0] ref_enc(input int op, input int rs, input int rt,
                                        input int rd, input int imm, output bit legal);
    bit [31:0] r;
    int i16;
    int i26;
    i16 = imm % 65536;
    i26 = imm % 67108864;
    legal = 1;
    case (op)
      0:  r = rs * 2**21 + rt * 2**16 + rd * 2**11 + 33;
      1:  r = rs * 2**21 + rt * 2**16 + rd * 2**11 + 35;
      2:  r = 13 * 2**26 + rs * 2**21 + rt * 2**16 + i16;
      3:  r = 35 * 2**26 + rs * 2**21 + rt * 2**16 + i16;
      4:  r = 43 * 2**26 + rs * 2**21 + rt * 2**16 + i16;
      5:  r = 4  * 2**26 + rs * 2**21 + rt * 2**16 + i16;
      6:  r = 15 * 2**26 + rt * 2**16 + i16;
      7:  r = 3  * 2**26 + i26;
      8:  r = 2  * 2**26 + i26;
      9:  r = rs * 2**21 + 8;
      10: r = 0;
      default: begin r = 0; legal = 0; end
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_sess = 0; m_cnt = 0; m_ill = 0; m_done = 0;
  endtask

  // One clock cycle: drive at edge+1, check ready, advance model, check outputs at next edge+1
  task automatic step(input bit s, input bit f, input bit v, input int op,
                      input int rs, input int rt, input int rd, input int imm);
    bit        rdy;
    bit        exp_we;
    int        exp_addr;
    bit [31:0] exp_dat;
    bit        lg;
    bit [31:0] w;
    start = s; finish = f; in_valid = v;
    in_op = 4'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_imm = 26'(imm);
    #1;
    rdy = m_sess && (m_cnt < DEPTH);
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    exp_we = 0; exp_addr = 0; exp_dat = 0;
    if (s) begin
      m_sess = 1; m_cnt = 0; m_ill = 0; m_done = 0;
    end else if (m_sess) begin
      if (v && rdy) begin
        w = ref_enc(op, rs, rt, rd, imm, lg);
        if (lg) begin
          exp_we = 1; exp_addr = m_cnt; exp_dat = w; m_cnt++;
        end else begin
          m_ill = 1;
        end
      end
      if (f || m_cnt == DEPTH) begin
        m_sess = 0; m_done = 1;
      end
    end
    @(posedge clk); #1;
    chk("im_we", {31'b0, im_we}, {31'b0, exp_we});
    if (exp_we) begin
      chk("im_addr", 32'(im_addr), 32'(exp_addr));
      chk("im_wdata", im_wdata, exp_dat);
    end
    chk("count", 32'(count), 32'(m_cnt));
    chk("illegal", {31'b0, illegal}, {31'b0, m_ill});
    chk("done", {31'b0, done}, {31'b0, m_done});
    chk("busy", {31'b0, busy}, {31'b0, m_sess});
  endtask

  task automatic idle_step();
    step(0, 0, 0, 10, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; start = 0; finish = 0; in_valid = 0;
    in_op = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", {31'b0, im_we}, 32'd0);
    chk("rst_addr", 32'(im_addr), 32'd0);
    chk("rst_wdata", im_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", {28'b0, in_ready, busy, done, illegal}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single addu
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 2, 3, 0);
    chk("t1_word", im_wdata, 32'h0022_1821);

    // ori / lui / sw back-to-back
    step(0, 0, 1, 2, 0, 8, 0, 'h1234);
    chk("t2_ori", im_wdata, 32'h3408_1234);
    step(0, 0, 1, 6, 0, 9, 0, 'hABCD);
    chk("t2_lui", im_wdata, 32'h3C09_ABCD);
    step(0, 0, 1, 4, 8, 9, 0, 4);
    chk("t2_sw", im_wdata, 32'hAD09_0004);

    // jal / jr
    step(0, 0, 1, 7, 0, 0, 0, 'hC00);
    chk("t3_jal", im_wdata, 32'h0C00_0C00);
    step(0, 0, 1, 9, 31, 0, 0, 0);
    chk("t3_jr", im_wdata, 32'h03E0_0008);

    // Illegal op: no write, sticky flag until next start
    step(0, 0, 1, 13, 1, 1, 1, 1);
    chk("t4_ill", {31'b0, illegal}, 32'd1);
    step(0, 0, 1, 15, 3, 3, 3, 3);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_clr", {31'b0, illegal}, 32'd0);

    // Fill the session with in_valid held; two extra requests must be refused
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 1, 1, i, i + 1, i + 2, 0);
    chk("t5_done", {31'b0, done}, 32'd1);
    chk("t5_busy", {31'b0, busy}, 32'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 4, 5, 6, 0);
    chk("t5_addr0", 32'(im_addr), 32'd0);

    // finish together with an accept still writes that word
    step(0, 1, 1, 2, 1, 2, 0, 'h55AA);
    idle_step();

    // Reset mid-stream after two writes
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 1, 1, 0);
    step(0, 0, 1, 0, 2, 2, 2, 0);
    reset = 1'b1;
    #1;
    chk("t6_we", {31'b0, im_we}, 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_ready", {31'b0, in_ready}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 0;
    idle_step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 9) < 7, int'($urandom_range(0, 15)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 67108863)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
